result_collect_control: RTL and testbench
=========================================

# result_collect_control

Output-side sequencer for the block-multiplication datapath, and the counterpart to the input-side mux controller that issues per-lane `mux_reset`.
- After a `start` pulse it waits a fixed number of accumulation cycles, then snapshots the four processing-lane accumulators in one cycle and pulses a per-lane `acc_clear`.
- It then serialises the snapshot onto a single valid/ready output stream, lane 0 first.
- It sits between the PE accumulator outputs and the result writer.

## Interface
Parameters:
- `DATA_W`, 16: width of one accumulator result.
- `LANES`, 4: number of PE lanes. Matches the 4-bit input mux reset vector.
- `ACC_CYCLES`, 4: cycles spent in ACCUM, where the PEs accumulate. Legal range is ≥1.

Ports:
- `clock`  in  1  single system clock. All logic is rising-edge.
- `reset`  in  1  asynchronous, active-high. Forces every register to its reset value immediately.
- `start`  in  1  one-cycle request to begin a collection run. Sampled only in IDLE.
- `lane_data`  in  LANES*DATA_W  accumulator outputs. Lane i occupies bits [i*DATA_W +: DATA_W].
- `acc_clear`  out  LANES  per-lane accumulator clear. Asserted all-ones for exactly the CAPTURE cycle.
- `out_data`  out  DATA_W  current serialised result.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the current beat.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- State machine states: IDLE, ACCUM, CAPTURE, DRAIN, DONE. The state is held in a register, and all outputs are decoded from registers, so outputs are glitch-free.
- IDLE:
  - `start`=1 → ACCUM, and the accumulation counter loads 0.
  - `start` seen in any other state is ignored. It is not queued.
- ACCUM:
  - The counter increments every cycle.
  - When counter == ACC_CYCLES-1 → CAPTURE.
- CAPTURE:
  - `lane_data` is latched into LANES shadow registers at the edge that leaves CAPTURE.
  - `acc_clear`=all ones during this cycle.
  - Lane index loads 0, then → DRAIN.
- DRAIN:
  - `out_valid`=1 and `out_data`=shadow[index].
  - On `out_valid` & `out_ready`: if index == LANES-1 → DONE, else index+1.
  - While `out_ready`=0, `out_data` and `out_valid` hold steady. There is no timeout.
  - Shadow registers are not rewritten during DRAIN. `lane_data` changes after CAPTURE have no effect.
- DONE: `done`=1 for one cycle, then → IDLE.
- Width rules:
  - Counter width is clog2(ACC_CYCLES)+1.
  - Index width is clog2(LANES), minimum 1.
  - Data passes through unmodified, with no arithmetic.
- Reset (values apply on assertion, asynchronously, including mid-run):
  - State IDLE, counter 0, index 0, shadows 0.
  - `acc_clear`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0.
  - A reset during DRAIN drops the remaining beats. No partial `done` is issued.
- `start` and reset deasserting in the same cycle: the `start` is lost. The first `start` honoured is on the first edge after reset is low.

## Timing
- `start` is sampled high at edge k. The run then proceeds:
  - ACCUM occupies cycles k+1 … k+ACC_CYCLES.
  - CAPTURE is cycle k+ACC_CYCLES+1.
  - The first `out_valid` is at cycle k+ACC_CYCLES+2.
- `busy` rises at k+1 and falls the cycle after DONE.
- With `out_ready` held 1:
  - Beats run one per cycle.
  - `done` falls in cycle k+ACC_CYCLES+2+LANES.
  - Total run length is ACC_CYCLES+LANES+2 cycles, which is 10 at the defaults.
- Each `out_ready` low cycle during DRAIN adds exactly one cycle.
- Back-to-back runs: the earliest next `start` is accepted in the cycle after DONE, i.e. the first IDLE cycle.

## Test plan
- Basic run:
  - Stimulus: reset high for 10 ns, then a `start` pulse. `lane_data`={16'h0004,16'h0003,16'h0002,16'h0001}, `out_ready`=1.
  - Response: `acc_clear`=4'b1111 in exactly one cycle, 5 cycles after `start`. Beats are 1, 2, 3, 4 on consecutive cycles, then `done` for one cycle.
- Backpressure:
  - Stimulus: basic run with `out_ready` low on beat 2 for 3 cycles.
  - Response: `out_data`=2 held stable with `out_valid`=1. `done` arrives 3 cycles later than in the basic run.
- Snapshot isolation:
  - Stimulus: change `lane_data` to all 16'hFFFF one cycle after CAPTURE.
  - Response: the output is still 1, 2, 3, 4.
- Ignored start:
  - Stimulus: pulse `start` during ACCUM and during DRAIN.
  - Response: exactly one run, one `done`, and `busy` low afterwards.
- Reset mid-DRAIN:
  - Stimulus: assert `reset` after beat 2 is accepted.
  - Response: `out_valid`, `busy`, `acc_clear` and `out_data` go to 0 immediately, with no `done`. A new `start` then yields a full 4-beat run.
- Back-to-back:
  - Stimulus: `start` in the first IDLE cycle after `done`.
  - Response: the second run is accepted, and its `acc_clear` pulse follows 5 cycles later.

Source files
------------

// File: rtl/result_collect_control.sv
// Output-side sequencer: waits ACC_CYCLES after start, snapshots all PE lane
// accumulators in one cycle, clears them, then streams the snapshot lane 0 first.
module result_collect_control #(
  parameter int DATA_W     = 16,
  parameter int LANES      = 4,
  parameter int ACC_CYCLES = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LANES*DATA_W-1:0]  lane_data,
  output logic [LANES-1:0]         acc_clear,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               fsm_state
);

  localparam int CNT_W = $clog2(ACC_CYCLES) + 1;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCUM   = 3'd1,
    S_CAPTURE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  index;
  logic [DATA_W-1:0] shadow [LANES];

  assign fsm_state = state;

  // Output stream handshake: a beat transfers on any rising edge where
  // out_valid and out_ready are both high; while out_valid is high and
  // out_ready is low, out_data and out_valid hold unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      index     <= '0;
      acc_clear <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < LANES; i++) shadow[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ACCUM;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        S_ACCUM: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(ACC_CYCLES - 1)) begin
            state     <= S_CAPTURE;
            acc_clear <= '1;
          end
        end
        S_CAPTURE: begin
          // Snapshot and the first beat come from the same edge, so lane 0 is
          // presented on the cycle DRAIN begins.
          for (int i = 0; i < LANES; i++) shadow[i] <= lane_data[i*DATA_W +: DATA_W];
          out_data  <= lane_data[DATA_W-1:0];
          out_valid <= 1'b1;
          acc_clear <= '0;
          index     <= '0;
          state     <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (index == IDX_W'(LANES - 1)) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              index    <= index + 1'b1;
              out_data <= shadow[index + 1'b1];
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          acc_clear <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_collect_control.sv
// Directed bench for result_collect_control: cycle-exact timing of one run,
// backpressure, snapshot isolation, ignored starts, mid-drain reset, back-to-back.
module tb_result_collect_control;

  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int ACC    = 4;

  logic                    clock;
  logic                    reset;
  logic                    start;
  logic [LANES*DATA_W-1:0] lane_data;
  logic [LANES-1:0]        acc_clear;
  logic [DATA_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic                    done;
  logic [2:0]              fsm_state;

  int checks   = 0;
  int failures = 0;

  localparam logic [LANES*DATA_W-1:0] BASE_DATA = {16'h0004, 16'h0003, 16'h0002, 16'h0001};

  result_collect_control #(.DATA_W(DATA_W), .LANES(LANES), .ACC_CYCLES(ACC)) dut (
    .clock(clock), .reset(reset), .start(start), .lane_data(lane_data),
    .acc_clear(acc_clear), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse start for one edge; returns at the negedge of the first ACCUM cycle.
  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (acc_clear !== 4'b0 || out_valid !== 1'b0 || out_data !== 16'h0 ||
        busy !== 1'b0 || done !== 1'b0 || fsm_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: clr=%b valid=%b data=%h busy=%b done=%b st=%0d required all 0",
               acc_clear, out_valid, out_data, busy, done, fsm_state);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Cycle-exact run with out_ready held high; cyc 1 is the first ACCUM cycle.
  task automatic test_basic();
    logic [3:0]  exp_clr;
    logic        exp_valid;
    logic [15:0] exp_data;
    lane_data = BASE_DATA;
    out_ready = 1'b1;
    do_start();
    for (int cyc = 1; cyc <= 11; cyc++) begin
      if (cyc > 1) @(negedge clock);
      exp_clr   = (cyc == 5) ? 4'b1111 : 4'b0000;
      exp_valid = (cyc >= 6 && cyc <= 9);
      exp_data  = 16'(cyc - 5);
      checks++;
      if (acc_clear !== exp_clr) begin
        failures++;
        $display("FAIL basic_acc_clear cyc=%0d: got %b required %b", cyc, acc_clear, exp_clr);
      end
      checks++;
      if (out_valid !== exp_valid || (exp_valid && out_data !== exp_data)) begin
        failures++;
        $display("FAIL basic_beat cyc=%0d: valid=%b data=%h required valid=%b data=%h",
                 cyc, out_valid, out_data, exp_valid, exp_data);
      end
      checks++;
      if (done !== (cyc == 10) || busy !== (cyc <= 10)) begin
        failures++;
        $display("FAIL basic_done_busy cyc=%0d: done=%b busy=%b required done=%b busy=%b",
                 cyc, done, busy, (cyc == 10), (cyc <= 10));
      end
    end
  endtask

  task automatic test_backpressure();
    logic        exp_valid;
    logic [15:0] exp_data;
    lane_data = BASE_DATA;
    out_ready = 1'b1;
    do_start();
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (cyc > 1) @(negedge clock);
      exp_valid = (cyc >= 6 && cyc <= 12);
      exp_data  = (cyc == 6) ? 16'd1 : (cyc <= 10) ? 16'd2 : (cyc == 11) ? 16'd3 : 16'd4;
      checks++;
      if (out_valid !== exp_valid || (exp_valid && out_data !== exp_data)) begin
        failures++;
        $display("FAIL bp_beat cyc=%0d: valid=%b data=%h required valid=%b data=%h",
                 cyc, out_valid, out_data, exp_valid, exp_data);
      end
      checks++;
      if (done !== (cyc == 13)) begin
        failures++;
        $display("FAIL bp_done cyc=%0d: got %b required %b", cyc, done, (cyc == 13));
      end
      out_ready = !(cyc >= 7 && cyc <= 9);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_snapshot();
    int beats = 0;
    lane_data = BASE_DATA;
    out_ready = 1'b1;
    do_start();
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc > 1) @(negedge clock);
      if (cyc == 6) lane_data = '1;
      if (out_valid) begin
        beats++;
        checks++;
        if (out_data !== 16'(beats)) begin
          failures++;
          $display("FAIL snapshot_beat%0d: got %h required %h", beats, out_data, 16'(beats));
        end
      end
    end
    checks++;
    if (beats != 4) begin
      failures++;
      $display("FAIL snapshot_count: got %0d beats required 4", beats);
    end
    lane_data = BASE_DATA;
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    int beats = 0;
    lane_data = BASE_DATA;
    out_ready = 1'b1;
    do_start();
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc > 1) @(negedge clock);
      if (done) dones++;
      if (out_valid) beats++;
      start = (cyc == 2 || cyc == 7);
    end
    start = 1'b0;
    checks++;
    if (dones != 1 || beats != 4) begin
      failures++;
      $display("FAIL ignored_start_runs: dones=%0d beats=%0d required 1 and 4", dones, beats);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ignored_start_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_reset_mid_drain();
    int dones = 0;
    int beats = 0;
    int wait_cyc = 0;
    lane_data = BASE_DATA;
    out_ready = 1'b1;
    do_start();
    repeat (7) @(negedge clock);   // cyc 8: beats 1 and 2 accepted
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || acc_clear !== 4'b0 ||
        out_data !== 16'h0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mid_drain_reset: valid=%b busy=%b clr=%b data=%h done=%b required all 0",
               out_valid, busy, acc_clear, out_data, done);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done || out_valid) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL mid_drain_no_done: %0d active cycles after reset, required 0", dones);
    end
    dones = 0;
    do_start();
    while (!done && wait_cyc < 30) begin
      if (out_valid) begin
        beats++;
        checks++;
        if (out_data !== 16'(beats)) begin
          failures++;
          $display("FAIL rerun_beat%0d: got %h required %h", beats, out_data, 16'(beats));
        end
      end
      @(negedge clock);
      wait_cyc++;
    end
    checks++;
    if (!done || beats != 4) begin
      failures++;
      $display("FAIL rerun_complete: done=%b beats=%0d required 1 and 4", done, beats);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    lane_data = BASE_DATA;
    out_ready = 1'b1;
    do_start();
    repeat (9) @(negedge clock);   // cyc 10: DONE
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_done: got %b required 1", done);
    end
    do_start();                    // start sampled at end of first IDLE cycle
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (cyc > 1) @(negedge clock);
      checks++;
      if (acc_clear !== ((cyc == 5) ? 4'b1111 : 4'b0000) || busy !== 1'b1) begin
        failures++;
        $display("FAIL b2b_second_run cyc=%0d: clr=%b busy=%b required clr=%b busy=1",
                 cyc, acc_clear, busy, (cyc == 5) ? 4'b1111 : 4'b0000);
      end
    end
    repeat (6) @(negedge clock);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    lane_data = BASE_DATA;
    test_reset();
    test_basic();
    @(negedge clock);
    test_backpressure();
    @(negedge clock);
    test_snapshot();
    test_ignored_start();
    test_reset_mid_drain();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
